// File: rtl/mult_wb_if.sv
// Wishbone slave-side bus bundle between the Caravel management SoC and the
// multiplier front-end. The master drives requests; the slave returns ack and read data.
interface mult_wb_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/mult_wb_slave.sv
// Wishbone register front-end for the 8x8 multiplier core: holds the A/B
// operands, waits MUL_LAT cycles for the combinational core to settle, then
// captures the 20-bit product and raises done / interrupt status.
// MUL_LAT must lie in 1..15 (the settle counter is 4 bits wide).
module mult_wb_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          MUL_LAT   = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,     // synchronous, active-low
    mult_wb_if.slave    wbs,
    output logic [7:0]  mul_a_o,
    output logic [7:0]  mul_b_o,
    input  logic [19:0] mul_p_i,
    output logic        irq_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(MUL_LAT - 1);

    localparam logic [1:0] REG_OPERAND = 2'd0;
    localparam logic [1:0] REG_CTRL    = 2'd1;
    localparam logic [1:0] REG_RESULT  = 2'd2;

    state_t      state_q,    state_d;
    logic [3:0]  lat_cnt_q,  lat_cnt_d;
    logic [7:0]  a_q,        a_d;
    logic [7:0]  b_q,        b_d;
    logic [19:0] result_q,   result_d;
    logic        irq_en_q,   irq_en_d;
    logic        overrun_q,  overrun_d;
    logic        done_q,     done_d;
    logic        busy_q,     busy_d;
    logic [7:0]  op_count_q, op_count_d;
    logic        ack_q,      ack_d;
    logic [31:0] dat_q,      dat_d;

    logic       accept;
    logic       hit;
    logic [1:0] reg_idx;
    logic       rd_hit;
    logic       wr_hit;

    // Holding ack for one cycle blocks the next accept, so acks are never back-to-back.
    assign accept  = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
    assign hit     = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_idx = wbs.wbs_adr_i[3:2];
    assign rd_hit  = accept & ~wbs.wbs_we_i & hit;
    assign wr_hit  = accept &  wbs.wbs_we_i & hit;

    // Next-state computation: bus decode, register updates and settle-counter sequencing.
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        irq_en_d   = irq_en_q;
        overrun_d  = overrun_q;
        done_d     = done_q;
        busy_d     = busy_q;
        op_count_d = op_count_q;
        ack_d      = accept;
        dat_d      = 32'h0;

        // Read data reflects the registers as they stand at the accept edge.
        if (rd_hit) begin
            case (reg_idx)
                REG_OPERAND: dat_d = {16'h0, a_q, b_q};
                REG_CTRL:    dat_d = {16'h0, op_count_q, 4'h0,
                                      done_q, busy_q, overrun_q, irq_en_q};
                REG_RESULT:  dat_d = {12'h0, result_q};
                default:     dat_d = 32'h0;
            endcase
        end

        // Reading the result acknowledges completion; a capture in the same
        // cycle is applied below and therefore overrides this clear.
        if (rd_hit && reg_idx == REG_RESULT) begin
            done_d = 1'b0;
        end

        if (wr_hit) begin
            case (reg_idx)
                REG_OPERAND: begin
                    if (state_q == ST_CALC) begin
                        // Operands must stay stable until capture; flag the lost write.
                        overrun_d = 1'b1;
                    end else begin
                        if (wbs.wbs_sel_i[0]) b_d = wbs.wbs_dat_i[7:0];
                        if (wbs.wbs_sel_i[1]) a_d = wbs.wbs_dat_i[15:8];
                        if (|wbs.wbs_sel_i[1:0]) begin
                            state_d   = ST_CALC;
                            lat_cnt_d = LAT_INIT;
                            busy_d    = 1'b1;
                            done_d    = 1'b0;
                        end
                    end
                end
                REG_CTRL: begin
                    if (wbs.wbs_sel_i[0]) begin
                        irq_en_d = wbs.wbs_dat_i[0];
                        if (wbs.wbs_dat_i[1]) overrun_d = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end

        // Count down the settle time, then capture the product.
        if (state_q == ST_CALC) begin
            if (lat_cnt_q == 4'd0) begin
                result_d   = mul_p_i;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                op_count_d = op_count_q + 8'd1;
                state_d    = ST_IDLE;
            end else begin
                lat_cnt_d = lat_cnt_q - 4'd1;
            end
        end
    end

    // State register with synchronous active-low reset; reset abandons any pending multiply.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= 4'd0;
            a_q        <= 8'h0;
            b_q        <= 8'h0;
            result_q   <= 20'h0;
            irq_en_q   <= 1'b0;
            overrun_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            op_count_q <= 8'h0;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            irq_en_q   <= irq_en_d;
            overrun_q  <= overrun_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            op_count_q <= op_count_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign mul_a_o       = a_q;
    assign mul_b_o       = b_q;
    assign irq_o         = done_q & irq_en_q;

    // Address byte offset, upper data bits and upper lanes have no register behind them.
    logic unused_bits;
    assign unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:16], wbs.wbs_sel_i[3:2]};

endmodule

// File: tb/tb_mult_wb_slave.sv
// Directed bench for mult_wb_slave: a vector table of bus accesses with
// hand-computed read data and interrupt level, plus hand-written sequences
// for settle timing, the capture/read race, reset mid-operation and the
// operation counter wrap.
module tb_mult_wb_slave;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] OP   = BASE + 32'h0;
    localparam logic [31:0] CS   = BASE + 32'h4;
    localparam logic [31:0] RS   = BASE + 32'h8;

    logic        clk;
    logic        rst_n;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [19:0] mul_p;
    logic        irq;

    int n_vec  = 0;
    int n_miss = 0;

    mult_wb_if wb ();

    mult_wb_slave #(.BASE_ADDR(BASE), .MUL_LAT(2)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wbs      (wb),
        .mul_a_o  (mul_a),
        .mul_b_o  (mul_b),
        .mul_p_i  (mul_p),
        .irq_o    (irq)
    );

    // Stand-in for the multiplier core.
    assign mul_p = 20'(mul_a) * 20'(mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Acknowledge must never be high in two consecutive cycles.
    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        if (wb.wbs_ack_o && ack_prev) begin
            n_miss = n_miss + 1;
            $display("FAIL ack_b2b: ack high in consecutive cycles, required isolated pulses");
        end
        ack_prev = wb.wbs_ack_o;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_irq;
        int          idle;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
        end
    endtask

    // One bus access, called on a falling edge; returns on the falling edge of the ack cycle.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
        for (int k = 0; k < 4 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (wb.wbs_ack_o) got = 1'b1;
        end
        rd = wb.wbs_dat_o;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        chk("ack", {31'h0, got}, 32'h1);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic chk_rd,
                                input logic [31:0] exp_rd, input logic exp_irq, input int idle);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_irq = exp_irq; v.idle = idle;
        return v;
    endfunction

    initial begin
        logic [31:0] rd;

        //            we   adr               dat            sel    chk  exp_rd        irq  idle
        tbl[0]  = mk(1'b0, CS,               32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b0, 2);
        tbl[1]  = mk(1'b1, OP,               32'h0000_FFFF, 4'h3, 1'b0, 32'h0,         1'b0, 2);
        tbl[2]  = mk(1'b0, CS,               32'h0,        4'hF, 1'b1, 32'h0000_0108, 1'b0, 2);
        tbl[3]  = mk(1'b0, RS,               32'h0,        4'hF, 1'b1, 32'h0000_FE01, 1'b0, 2);
        tbl[4]  = mk(1'b0, CS,               32'h0,        4'hF, 1'b1, 32'h0000_0100, 1'b0, 2);
        tbl[5]  = mk(1'b0, OP,               32'h0,        4'hF, 1'b1, 32'h0000_FFFF, 1'b0, 2);
        tbl[6]  = mk(1'b1, CS,               32'h1,        4'h1, 1'b0, 32'h0,         1'b0, 2);
        tbl[7]  = mk(1'b1, OP,               32'h0000_0305, 4'h3, 1'b0, 32'h0,         1'b0, 0);
        tbl[8]  = mk(1'b1, OP,               32'h0000_0909, 4'h3, 1'b0, 32'h0,         1'b1, 2);
        tbl[9]  = mk(1'b0, CS,               32'h0,        4'hF, 1'b1, 32'h0000_020B, 1'b1, 2);
        tbl[10] = mk(1'b0, RS,               32'h0,        4'hF, 1'b1, 32'h0000_000F, 1'b0, 2);
        tbl[11] = mk(1'b0, OP,               32'h0,        4'hF, 1'b1, 32'h0000_0305, 1'b0, 2);
        tbl[12] = mk(1'b1, CS,               32'h3,        4'h1, 1'b0, 32'h0,         1'b0, 2);
        tbl[13] = mk(1'b0, CS,               32'h0,        4'hF, 1'b1, 32'h0000_0201, 1'b0, 2);
        tbl[14] = mk(1'b1, OP,               32'h0000_0002, 4'h1, 1'b0, 32'h0,         1'b0, 2);
        tbl[15] = mk(1'b0, RS,               32'h0,        4'hF, 1'b1, 32'h0000_0006, 1'b0, 2);
        tbl[16] = mk(1'b1, OP,               32'h0000_AB77, 4'h2, 1'b0, 32'h0,         1'b0, 2);
        tbl[17] = mk(1'b0, OP,               32'h0,        4'hF, 1'b1, 32'h0000_AB02, 1'b1, 2);
        tbl[18] = mk(1'b0, RS,               32'h0,        4'hF, 1'b1, 32'h0000_0156, 1'b0, 2);
        tbl[19] = mk(1'b1, CS,               32'h0,        4'h2, 1'b0, 32'h0,         1'b0, 2);
        tbl[20] = mk(1'b0, CS,               32'h0,        4'hF, 1'b1, 32'h0000_0401, 1'b0, 2);
        tbl[21] = mk(1'b0, BASE + 32'hC,     32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b0, 2);
        tbl[22] = mk(1'b1, BASE + 32'hC,     32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         1'b0, 2);
        tbl[23] = mk(1'b0, BASE + 32'h10,    32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b0, 2);
        tbl[24] = mk(1'b1, BASE + 32'h10,    32'h0000_1234, 4'h3, 1'b0, 32'h0,         1'b0, 2);
        tbl[25] = mk(1'b0, CS,               32'h0,        4'hF, 1'b1, 32'h0000_0401, 1'b0, 2);
        tbl[26] = mk(1'b1, OP,               32'h0000_1111, 4'hC, 1'b0, 32'h0,         1'b0, 2);
        tbl[27] = mk(1'b0, CS,               32'h0,        4'hF, 1'b1, 32'h0000_0401, 1'b0, 2);
        tbl[28] = mk(1'b0, OP,               32'h0,        4'hF, 1'b1, 32'h0000_AB02, 1'b0, 2);
        tbl[29] = mk(1'b0, 32'h0000_0000,    32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b0, 2);
        tbl[30] = mk(1'b1, 32'h2000_0000,    32'h0000_FFFF, 4'h3, 1'b0, 32'h0,         1'b0, 2);
        tbl[31] = mk(1'b0, CS,               32'h0,        4'hF, 1'b1, 32'h0000_0401, 1'b0, 2);

        // Reset held for two cycles with a live strobe.
        rst_n        = 1'b0;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'hF;
        wb.wbs_adr_i = CS;
        wb.wbs_dat_i = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack",   {31'h0, wb.wbs_ack_o}, 32'h0);
        chk("rst_dat",   wb.wbs_dat_o, 32'h0);
        chk("rst_mul_a", {24'h0, mul_a}, 32'h0);
        chk("rst_mul_b", {24'h0, mul_b}, 32'h0);
        chk("rst_irq",   {31'h0, irq}, 32'h0);
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);

        // Table-driven register accesses.
        for (int i = 0; i < NV; i++) begin
            xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, tbl[i].exp_irq});
            $display("vec %0d: we=%0b adr=0x%08h dat=0x%08h sel=%b rd=0x%08h irq=%0b",
                     i, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd, irq);
            repeat (tbl[i].idle) @(negedge clk);
        end

        // Settle timing: operands visible next cycle, irq rises two cycles later.
        xfer(1'b1, OP, 32'h0000_FFFF, 4'h3, rd);
        chk("seqA_mul_a", {24'h0, mul_a}, 32'h0000_00FF);
        chk("seqA_mul_b", {24'h0, mul_b}, 32'h0000_00FF);
        chk("seqA_irq_t1", {31'h0, irq}, 32'h0);
        @(negedge clk);
        chk("seqA_irq_t2", {31'h0, irq}, 32'h0);
        chk("seqA_mul_a_hold", {24'h0, mul_a}, 32'h0000_00FF);
        @(negedge clk);
        chk("seqA_irq_t3", {31'h0, irq}, 32'h1);
        xfer(1'b0, RS, 32'h0, 4'hF, rd);
        chk("seqA_result", rd, 32'h0000_FE01);
        $display("seqA: settle timing, result=0x%08h", rd);
        repeat (2) @(negedge clk);

        // Result read lands on the capture edge: old result returned, done still set.
        xfer(1'b1, OP, 32'h0000_0404, 4'h3, rd);
        xfer(1'b0, RS, 32'h0, 4'hF, rd);
        chk("seqD_old_result", rd, 32'h0000_FE01);
        chk("seqD_irq_set_wins", {31'h0, irq}, 32'h1);
        repeat (2) @(negedge clk);
        xfer(1'b0, RS, 32'h0, 4'hF, rd);
        chk("seqD_new_result", rd, 32'h0000_0010);
        repeat (2) @(negedge clk);
        xfer(1'b0, CS, 32'h0, 4'hF, rd);
        chk("seqD_status", rd, 32'h0000_0601);
        $display("seqD: capture/read race, status=0x%08h", rd);
        repeat (2) @(negedge clk);

        // Reset during the first calculation cycle abandons the multiply.
        xfer(1'b1, OP, 32'h0000_0305, 4'h3, rd);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("seqB_ack",   {31'h0, wb.wbs_ack_o}, 32'h0);
        chk("seqB_dat",   wb.wbs_dat_o, 32'h0);
        chk("seqB_mul_a", {24'h0, mul_a}, 32'h0);
        chk("seqB_mul_b", {24'h0, mul_b}, 32'h0);
        chk("seqB_irq",   {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("seqB_irq_after", {31'h0, irq}, 32'h0);
        xfer(1'b0, RS, 32'h0, 4'hF, rd);
        chk("seqB_result", rd, 32'h0);
        repeat (2) @(negedge clk);
        xfer(1'b0, CS, 32'h0, 4'hF, rd);
        chk("seqB_status", rd, 32'h0);
        $display("seqB: reset mid-operation, status=0x%08h", rd);
        repeat (2) @(negedge clk);

        // 256 multiplies wrap the operation counter back to zero.
        for (int n = 1; n <= 256; n++) begin
            xfer(1'b1, OP, 32'h0000_0101, 4'h1, rd);
            repeat (3) @(negedge clk);
            if (n == 255) begin
                xfer(1'b0, CS, 32'h0, 4'hF, rd);
                chk("seqC_count_ff", rd, 32'h0000_FF08);
                repeat (2) @(negedge clk);
            end
        end
        xfer(1'b0, CS, 32'h0, 4'hF, rd);
        chk("seqC_count_wrap", rd, 32'h0000_0008);
        $display("seqC: counter wrap, status=0x%08h", rd);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mult_wb_slave.md
# mult_wb_slave

Wishbone slave front-end for the 8x8 low-power multiplier. Decodes Caravel management-SoC bus cycles, holds the operand registers that drive the multiplier's `A`/`B` inputs, and waits a fixed settle time. It then captures the 20-bit `PO` product into a result register and raises done/IRQ status. It sits between the `user_project_wrapper` Wishbone pins and the multiplier core, replacing the direct `wbs_dat_i` → `A`/`B` and `PO` → `wbs_dat_o` wiring.

## Interface
- `BASE_ADDR`, default `32'h3000_0000`: register block base; decode compares `adr_i[31:4]`.
- `MUL_LAT`, default `2`: cycles allowed for the multiplier to settle. Legal range 1..15.

- `wb_clk_i`  in  1  sole clock; all state on rising edge.
- `wb_rst_i`  in  1  **synchronous, active-low** reset.
- `wbs_stb_i`  in  1  strobe.
- `wbs_cyc_i`  in  1  cycle valid.
- `wbs_we_i`  in  1  1 = write.
- `wbs_sel_i`  in  4  byte lane enables.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data; valid while `wbs_ack_o` = 1, otherwise 0.
- `mul_a_o`  out  8  to multiplier `A`.
- `mul_b_o`  out  8  to multiplier `B`.
- `mul_p_i`  in  20  from multiplier `PO`.
- `irq_o`  out  1  level interrupt, equal to `done & irq_en`.

## Operation
- Register map, selected by `adr_i[3:2]` when `adr_i[31:4] == BASE_ADDR[31:4]`:
  - 0x0 OPERAND (RW): `[7:0]` B, `[15:8]` A.
  - 0x4 CTRL/STATUS. Write: bit0 `irq_en`; bit1 = 1 clears `overrun`. Read: bit0 `irq_en`, bit1 `overrun`, bit2 `busy`, bit3 `done`, `[15:8]` `op_count`.
  - 0x8 RESULT (RO): `{12'b0, result[19:0]}`.
  - 0xC: reads 0, writes ignored.
- Accept condition: `stb & cyc & !ack_o`. Every accepted access is acked, including non-matching addresses, which read 0 and ignore writes.
- OPERAND write:
  - `sel[0]` updates B; `sel[1]` updates A.
  - The write launches a multiply if either lane is set and FSM = IDLE.
  - If FSM = CALC: registers are not changed, the access is still acked, and `overrun` is set.
- FSM states:
  - IDLE → CALC on launch: load `lat_cnt = MUL_LAT-1`, set `busy`, clear `done`.
  - CALC: decrement `lat_cnt`. When `lat_cnt == 0`:
    - `result <= mul_p_i`
    - `done <= 1`
    - `busy <= 0`
    - `op_count <= op_count + 1`, 8-bit, wrapping 0xFF → 0x00
    - → IDLE.
- A RESULT read clears `done`. If the read completes in the same cycle that CALC finishes, the set wins and `done` = 1.
- A RESULT read while busy returns the previous result.
- CTRL writes need `sel[0]`; otherwise they are ignored.
- Reset (any cycle, including mid-CALC): FSM IDLE. `ack_o`, `dat_o`, `mul_a_o`, `mul_b_o`, `result`, `irq_en`, `overrun`, `done`, `busy`, `op_count`, and `irq_o` all reset to 0. A pending multiply is abandoned.

## Timing
- Access accepted at edge t; `ack_o` = 1 for exactly cycle t+1, with read data registered at t.
- Minimum spacing between accepts: 2 cycles. `ack_o` never high in consecutive cycles.
- OPERAND write accepted at t: `mul_a_o`/`mul_b_o` update at t+1. FSM is in CALC for cycles t+1 … t+MUL_LAT.
- Result capture edge is t+MUL_LAT. `done`/`irq_o` go high and `busy` goes low in cycle t+MUL_LAT+1.
- Operand outputs are held stable from launch through capture.
- Status reads reflect register state at the accept edge.

## Test plan
- Reset: assert `wb_rst_i` = 0 for 2 cycles with `stb` active → `ack_o` = 0, all outputs 0. Release, then read STATUS → 0x0000_0000.
- Basic multiply, MUL_LAT = 2:
  - Stimulus: write OPERAND 0x0000_FFFF with sel = 4'b0011.
  - Response: `mul_a_o` = `mul_b_o` = 0xFF one cycle later; `done` rises 2 cycles after that; RESULT reads 0x0000_FE01; STATUS `[15:8]` = 0x01.
  - A second STATUS read shows `done` = 0.
- Overrun:
  - Stimulus: with `irq_en` = 1, write 0x0305 (A = 3, B = 5); while `busy`, write 0x0909.
  - Response: second write acked, `overrun` = 1, result = 0x0000F (15), `irq_o` = 1 until RESULT is read.
  - Write CTRL 0x3 → `overrun` = 0, `irq_en` = 1.
- Byte lanes: write 0x0000_AB77 with sel = 4'b0010 after B = 0x02 → A = 0xAB, B = 0x02, result 0x156.
- Reset mid-operation: launch, then assert reset in the first CALC cycle → `busy`/`done`/`irq_o` stay 0, RESULT reads 0, `op_count` = 0.
- Decode and counter:
  - Accesses at BASE_ADDR + 0xC and BASE_ADDR + 0x10 → acked, read 0.
  - 256 multiplies → `op_count` wraps to 0x00.
  - `ack_o` is never high in back-to-back cycles under continuous `stb`.
